// File: rtl/branch_flag_unit_if.sv
// Bus between the EX-stage ALU/branch inputs, the branch_flag_unit and fetch redirect.
// master = upstream driver (ALU, decode, fetch), slave = branch_flag_unit.
interface branch_flag_unit_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  alu_valid;
    logic                  alu_set_flags;
    logic                  alu_zero;
    logic                  alu_negative;
    logic                  alu_carry;
    logic                  alu_overflow;

    logic                  br_valid;
    logic [1:0]            br_type;
    logic [3:0]            br_cond;
    logic                  br_reg_zero;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  br_ready;

    logic [3:0]            flags_q;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  redirect_ready;

    logic                  br_resolved;
    logic                  br_taken;

    modport master (
        output alu_valid, alu_set_flags, alu_zero, alu_negative, alu_carry, alu_overflow,
        output br_valid, br_type, br_cond, br_reg_zero, br_target,
        output redirect_ready,
        input  br_ready, flags_q, redirect_valid, redirect_pc, br_resolved, br_taken
    );

    modport slave (
        input  alu_valid, alu_set_flags, alu_zero, alu_negative, alu_carry, alu_overflow,
        input  br_valid, br_type, br_cond, br_reg_zero, br_target,
        input  redirect_ready,
        output br_ready, flags_q, redirect_valid, redirect_pc, br_resolved, br_taken
    );
endinterface

// File: rtl/branch_flag_unit.sv
// EX-stage NZCV flag register and conditional branch resolver with a
// valid/ready redirect to fetch; branch acceptance stalls while a redirect is pending.
module branch_flag_unit #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    branch_flag_unit_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } state_e;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic cond_holds(input logic [3:0] cond, input nzcv_t f);
        logic r;
        unique case (cond)
            4'd0:    r = f.z;
            4'd1:    r = !f.z;
            4'd2:    r = f.c;
            4'd3:    r = !f.c;
            4'd4:    r = f.n;
            4'd5:    r = !f.n;
            4'd6:    r = f.v;
            4'd7:    r = !f.v;
            4'd8:    r = f.c && !f.z;
            4'd9:    r = !f.c || f.z;
            4'd10:   r = (f.n == f.v);
            4'd11:   r = (f.n != f.v);
            4'd12:   r = !f.z && (f.n == f.v);
            4'd13:   r = f.z || (f.n != f.v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    state_e                state_q,          state_d;
    nzcv_t                 flags_q,          flags_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q,    redirect_pc_d;
    logic                  br_resolved_q,    br_resolved_d;
    logic                  br_taken_q,       br_taken_d;
    logic                  br_ready_q,       br_ready_d;

    logic  flag_update;
    nzcv_t live_flags;
    nzcv_t eff_flags;
    logic  br_take;

    // Same-cycle flag-setting op forwards its flags to a B.cond.
    assign flag_update = bus.alu_valid && bus.alu_set_flags;
    assign live_flags  = '{n: bus.alu_negative, z: bus.alu_zero,
                           c: bus.alu_carry,    v: bus.alu_overflow};
    assign eff_flags   = flag_update ? live_flags : flags_q;

    always_comb begin
        unique case (br_type_e'(bus.br_type))
            BR_B:    br_take = 1'b1;
            BR_COND: br_take = cond_holds(bus.br_cond, eff_flags);
            BR_CBZ:  br_take = bus.br_reg_zero;
            default: br_take = !bus.br_reg_zero;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
        state_d          = state_q;
        flags_d          = flag_update ? live_flags : flags_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        br_resolved_d    = 1'b0;
        br_taken_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    br_resolved_d = 1'b1;
                    br_taken_d    = br_take;
                    if (br_take) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = bus.br_target;
                        state_d          = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                // br_valid is deliberately ignored here; upstream stalls on br_ready.
                if (redirect_valid_q && bus.redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        br_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            flags_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_resolved_q    <= 1'b0;
            br_taken_q       <= 1'b0;
            br_ready_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q          <= state_d;
            flags_q          <= flags_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_resolved_q    <= br_resolved_d;
            br_taken_q       <= br_taken_d;
            br_ready_q       <= br_ready_d;
        end
    end

    assign bus.flags_q        = flags_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.br_resolved    = br_resolved_q;
    assign bus.br_taken       = br_taken_q;
    assign bus.br_ready       = br_ready_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: directed scenarios, a full condition
// sweep and randomized traffic, all scored against a transaction-level reference model.
module tb_branch_flag_unit;

    localparam int AW = 64;

    logic clk;
    logic reset;

    branch_flag_unit_if #(.ADDR_WIDTH(AW)) bus ();

    branch_flag_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]    m_flags;
    logic          m_pending;
    logic [AW-1:0] m_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM-style evaluation: pairs of codes share a base test, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'd15) return 1'b1;
        return cond[0] ? !base : base;
    endfunction

    task automatic zero_inputs();
        bus.alu_valid      = 0;
        bus.alu_set_flags  = 0;
        bus.alu_zero       = 0;
        bus.alu_negative   = 0;
        bus.alu_carry      = 0;
        bus.alu_overflow   = 0;
        bus.br_valid       = 0;
        bus.br_type        = 0;
        bus.br_cond        = 0;
        bus.br_reg_zero    = 0;
        bus.br_target      = '0;
        bus.redirect_ready = 0;
    endtask

    task automatic model_reset();
        m_flags   = 4'b0000;
        m_pending = 1'b0;
        m_pc      = '0;
    endtask

    task automatic check_all(input string tag, input logic exp_res, input logic exp_tak);
        check({tag, ".flags"},    bus.flags_q,        m_flags);
        check({tag, ".rvalid"},   bus.redirect_valid, m_pending);
        check({tag, ".rpc"},      bus.redirect_pc,    m_pc);
        check({tag, ".ready"},    bus.br_ready,       !m_pending);
        check({tag, ".resolved"}, bus.br_resolved,    exp_res);
        check({tag, ".taken"},    bus.br_taken,       exp_tak);
    endtask

    // Predict the effect of the currently driven inputs, clock once, compare.
    task automatic cycle(input string tag);
        logic       upd, taken, exp_res, exp_tak;
        logic [3:0] live, eff;
        upd     = bus.alu_valid && bus.alu_set_flags;
        live    = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        eff     = upd ? live : m_flags;
        exp_res = 1'b0;
        exp_tak = 1'b0;
        if (!m_pending) begin
            if (bus.br_valid) begin
                case (bus.br_type)
                    2'd0:    taken = 1'b1;
                    2'd1:    taken = ref_cond(bus.br_cond, eff);
                    2'd2:    taken = bus.br_reg_zero;
                    default: taken = !bus.br_reg_zero;
                endcase
                exp_res = 1'b1;
                exp_tak = taken;
                if (taken) begin
                    m_pending = 1'b1;
                    m_pc      = bus.br_target;
                end
            end
        end else if (bus.redirect_ready) begin
            m_pending = 1'b0;
        end
        if (upd) m_flags = live;
        @(posedge clk);
        #1;
        check_all(tag, exp_res, exp_tak);
    endtask

    task automatic set_alu(input logic set_flags, input logic [3:0] nzcv);
        bus.alu_valid     = 1;
        bus.alu_set_flags = set_flags;
        {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = nzcv;
    endtask

    task automatic set_br(input logic [1:0] typ, input logic [3:0] cond,
                          input logic reg_zero, input logic [AW-1:0] target);
        bus.br_valid    = 1;
        bus.br_type     = typ;
        bus.br_cond     = cond;
        bus.br_reg_zero = reg_zero;
        bus.br_target   = target;
    endtask

    initial begin
        // Reset with every input driven high
        bus.alu_valid = 1; bus.alu_set_flags = 1; bus.alu_zero = 1; bus.alu_negative = 1;
        bus.alu_carry = 1; bus.alu_overflow = 1; bus.br_valid = 1; bus.br_type = 2'b11;
        bus.br_cond = 4'hf; bus.br_reg_zero = 1; bus.br_target = '1; bus.redirect_ready = 1;
        reset = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0);
        zero_inputs();
        reset = 1;
        cycle("post_reset");

        // Flag latch, then a non-flag op leaves the register alone
        set_alu(1'b1, 4'b0110);
        cycle("flag_latch");
        check("flag_latch.value", bus.flags_q, 4'b0110);
        set_alu(1'b0, 4'b0000);
        cycle("flag_hold");
        check("flag_hold.value", bus.flags_q, 4'b0110);

        // Forwarding: flags_q=0000, same-cycle SUBS Z=1 with B.EQ
        set_alu(1'b1, 4'b0000);
        cycle("fwd_clear");
        set_alu(1'b1, 4'b0100);
        set_br(2'b01, 4'd0, 1'b0, 64'h400);
        cycle("fwd");
        check("fwd.taken", bus.br_taken, 1'b1);
        check("fwd.pc", bus.redirect_pc, 64'h400);
        zero_inputs();
        bus.redirect_ready = 1;
        cycle("fwd_ack");
        zero_inputs();

        // CBZ not taken, CBNZ taken
        set_br(2'b10, 4'd0, 1'b0, 64'h123);
        cycle("cbz");
        check("cbz.taken", bus.br_taken, 1'b0);
        check("cbz.rvalid", bus.redirect_valid, 1'b0);
        set_br(2'b11, 4'd0, 1'b0, 64'h80);
        cycle("cbnz");
        check("cbnz.pc", bus.redirect_pc, 64'h80);
        zero_inputs();
        bus.redirect_ready = 1;
        cycle("cbnz_ack");
        zero_inputs();

        // Backpressure: pending redirect holds, new branches ignored
        set_br(2'b00, 4'd0, 1'b0, 64'hdead_beef_0000_1000);
        cycle("bp_take");
        for (int i = 0; i < 4; i++) begin
            set_br(2'($urandom), 4'($urandom), 1'($urandom), {$urandom, $urandom});
            bus.redirect_ready = 0;
            cycle("bp_hold");
            check("bp_hold.pc", bus.redirect_pc, 64'hdead_beef_0000_1000);
            check("bp_hold.resolved", bus.br_resolved, 1'b0);
        end
        zero_inputs();
        bus.redirect_ready = 1;
        cycle("bp_release");
        check("bp_release.ready", bus.br_ready, 1'b1);
        check("bp_release.rvalid", bus.redirect_valid, 1'b0);
        zero_inputs();

        // Reset mid-redirect drops the request at once
        set_br(2'b00, 4'd0, 1'b0, 64'h55);
        cycle("mid_take");
        zero_inputs();
        #2 reset = 0;
        model_reset();
        #1;
        check_all("mid_reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1;
        cycle("mid_release");

        // Condition sweep: every code against every flag value
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                zero_inputs();
                set_alu(1'b1, 4'(f));
                cycle("sweep_flags");
                zero_inputs();
                set_br(2'b01, 4'(c), 1'b0, 64'(f * 16 + c));
                bus.redirect_ready = 1;
                cycle("sweep_br");
                check("sweep.taken", bus.br_taken, ref_cond(4'(c), 4'(f)));
                if (f == 9 && c == 10) check("ge_n1v1", bus.br_taken, 1'b1);
                if (f == 9 && c == 11) check("lt_n1v1", bus.br_taken, 1'b0);
                zero_inputs();
                bus.redirect_ready = 1;
                cycle("sweep_ack");
            end
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.alu_valid      = 1'($urandom);
            bus.alu_set_flags  = 1'($urandom);
            bus.alu_zero       = 1'($urandom);
            bus.alu_negative   = 1'($urandom);
            bus.alu_carry      = 1'($urandom);
            bus.alu_overflow   = 1'($urandom);
            bus.br_valid       = ($urandom_range(0, 2) != 0);
            bus.br_type        = 2'($urandom);
            bus.br_cond        = 4'($urandom);
            bus.br_reg_zero    = 1'($urandom);
            bus.br_target      = {$urandom, $urandom};
            bus.redirect_ready = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Sits directly downstream of the ALU and its zero_detection output in the EX stage.
- Registers the NZCV condition flags from flag-setting ALU ops and resolves conditional branches (B, B.cond, CBZ, CBNZ).
- Forwards the in-flight flags to a same-cycle B.cond.
- Issues a redirect to fetch through a valid/ready handshake and holds new branch acceptance while a redirect is pending.

Parameters:
ADDR_WIDTH, 64, width of branch target and redirect PC

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
alu_valid  input  1  ALU result valid this cycle
alu_set_flags  input  1  current ALU op updates flags (ADDS/SUBS/ANDS)
alu_zero  input  1  zero flag from zero_detection
alu_negative  input  1  ALU result bit 63
alu_carry  input  1  ALU carry out
alu_overflow  input  1  ALU signed overflow
br_valid  input  1  branch instruction presented this cycle
br_type  input  2  00=B, 01=B.cond, 10=CBZ, 11=CBNZ
br_cond  input  4  ARM condition code for B.cond
br_reg_zero  input  1  zero-detect of the CBZ/CBNZ test register
br_target  input  ADDR_WIDTH  computed branch target
br_ready  output  1  unit can accept a branch this cycle
flags_q  output  4  registered {N,Z,C,V}
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  ADDR_WIDTH  target of redirect
redirect_ready  input  1  fetch accepts redirect
br_resolved  output  1  one-cycle pulse: a branch was resolved (taken or not)
br_taken  output  1  valid with br_resolved: resolution result

Behaviour:
- Reset (reset=0, async): flags_q=4'b0000, redirect_valid=0, redirect_pc=0, br_resolved=0, br_taken=0, state=IDLE. Reset mid-redirect drops the request immediately; no branch is resolved after release.
- Flag register: on a clock edge with alu_valid & alu_set_flags, flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow}. Otherwise flags_q holds. Updates occur in every state.
- Effective flags for B.cond: if alu_valid & alu_set_flags in the same cycle, use the live ALU flags (forwarding); else use flags_q.
- Condition evaluation, br_cond encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14, 15 always.
- Taken rule: B always taken; CBZ taken iff br_reg_zero=1; CBNZ taken iff br_reg_zero=0; B.cond taken iff the condition is true.
- State machine, 2 states:
  - IDLE: br_ready=1. A branch is accepted on br_valid. On the next cycle br_resolved=1 and br_taken=result (1-cycle latency, both registered). If taken, the same edge sets redirect_valid=1 and redirect_pc=br_target, and the state goes to REDIRECT. If not taken, the state stays IDLE.
  - REDIRECT: br_ready=0. br_valid is ignored (upstream must stall). redirect_valid and redirect_pc are held stable until a cycle where redirect_valid & redirect_ready. On the edge after that handshake: redirect_valid=0, state=IDLE.
- A redirect accepted in its first cycle lets a new branch be accepted 2 cycles after the original branch.
- br_resolved and br_taken are single-cycle pulses; both are 0 in all other cycles.
- br_taken=0 whenever br_resolved=0.
- Same-cycle events:
  - Flag-setting ALU op plus B.cond in IDLE: forwarded flags decide the branch, and flags_q also updates.
  - Flag-setting ALU op in REDIRECT: flags_q updates; there is no other effect.
- Undefined br_type values: none (all 4 encodings are defined).

Test Plan:
- Reset: hold reset=0 for 3 cycles after driving all inputs to 1 -> flags_q=0000, redirect_valid=0, br_resolved=0; release; first clean edge leaves all outputs 0.
- Flag latch: SUBS with alu_zero=1, carry=1 and others 0 -> next cycle flags_q=4'b0110. Non-flag ADD with alu_zero=0 -> flags_q stays 0110.
- Forwarding: flags_q=0000; same cycle, SUBS with zero=1 and B.cond EQ, target 64'h400 -> next cycle br_resolved=1, br_taken=1, redirect_valid=1, redirect_pc=64'h400.
- CBZ/CBNZ: CBZ with br_reg_zero=0 -> br_resolved=1, br_taken=0, no redirect. CBNZ with br_reg_zero=0, target 64'h80 -> redirect_pc=64'h80.
- Redirect backpressure: taken B with redirect_ready held 0 for 4 cycles -> redirect_valid stays 1, redirect_pc stable, br_ready=0, and br_valid during this time is not resolved. redirect_ready=1 -> next cycle redirect_valid=0, br_ready=1.
- Condition sweep: all 16 br_cond values × all 16 flags_q values vs a reference model -> br_taken matches the table. GE with N=1,V=1 is taken; LT with N=1,V=1 is not taken.
